// File: rtl/dmem_access_unit.sv
// dmem_access_unit: RV32I MEM-stage load/store unit in front of a
// word-only DataMemory; sub-word stores become a two-cycle RMW.
module dmem_access_unit #(
   parameter int MEM_DEPTH = 16384
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_mem_read,
   input  logic        req_mem_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] load_data,
   output logic        stall,
   output logic        access_fault,
   output logic [1:0]  fault_cause,
   output logic [31:0] rmw_count,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_din,
   output logic        dmem_mem_read,
   output logic        dmem_mem_write,
   input  logic [31:0] dmem_dout
);

   typedef enum logic {
      IDLE,
      RMW_WR
   } state_t;

   localparam logic [2:0] F_B  = 3'b000;
   localparam logic [2:0] F_H  = 3'b001;
   localparam logic [2:0] F_W  = 3'b010;
   localparam logic [2:0] F_BU = 3'b100;
   localparam logic [2:0] F_HU = 3'b101;

   localparam logic [29:0] DEPTH_W = 30'(MEM_DEPTH);

   state_t      state_q;
   state_t      state_d;
   logic [31:0] addr_q;
   logic [31:0] addr_d;
   logic [31:0] merged_q;
   logic [31:0] merged_d;
   logic [31:0] rmw_q;
   logic        rmw_done;

   logic        any_req;
   logic        illegal;
   logic        misaligned;
   logic        out_range;
   logic [1:0]  cause;
   logic [31:0] word_addr;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] ext_data;
   logic [31:0] merged_word;

   assign any_req   = req_mem_read | req_mem_write;
   assign word_addr = {req_addr[31:2], 2'b00};

   always_comb begin
      illegal = req_mem_read & req_mem_write;
      unique case (req_funct3)
         F_B, F_H, F_W: ;
         F_BU, F_HU: begin
            if (req_mem_write) illegal = 1'b1;
         end
         default: begin
            if (any_req) illegal = 1'b1;
         end
      endcase
   end

   assign misaligned = any_req &
      (((req_funct3 == F_W) && (req_addr[1:0] != 2'b00)) |
       ((req_funct3[1:0] == 2'b01) && req_addr[0]));

   assign out_range = any_req & (req_addr[31:2] >= DEPTH_W);

   // Several checks can fire together; the first match wins.
   always_comb begin
      priority case (1'b1)
         illegal:    cause = 2'b11;
         misaligned: cause = 2'b01;
         out_range:  cause = 2'b10;
         default:    cause = 2'b00;
      endcase
   end

   always_comb begin
      unique case (req_addr[1:0])
         2'b00: sel_byte = dmem_dout[7:0];
         2'b01: sel_byte = dmem_dout[15:8];
         2'b10: sel_byte = dmem_dout[23:16];
         2'b11: sel_byte = dmem_dout[31:24];
      endcase
      sel_half = req_addr[1] ? dmem_dout[31:16]
                             : dmem_dout[15:0];
   end

   always_comb begin
      unique case (req_funct3)
         F_B:     ext_data = {{24{sel_byte[7]}}, sel_byte};
         F_BU:    ext_data = {24'h0, sel_byte};
         F_H:     ext_data = {{16{sel_half[15]}}, sel_half};
         F_HU:    ext_data = {16'h0, sel_half};
         F_W:     ext_data = dmem_dout;
         default: ext_data = 32'h0;
      endcase
   end

   // Only sb (funct3[0]=0) and sh (funct3[0]=1) reach the merge.
   always_comb begin
      merged_word = dmem_dout;
      if (req_funct3[0]) begin
         merged_word[{req_addr[1], 4'b0000} +: 16] =
            req_wdata[15:0];
      end else begin
         merged_word[{req_addr[1:0], 3'b000} +: 8] =
            req_wdata[7:0];
      end
   end

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      merged_d       = merged_q;
      rmw_done       = 1'b0;
      load_data      = 32'h0;
      stall          = 1'b0;
      access_fault   = 1'b0;
      fault_cause    = 2'b00;
      dmem_addr      = 32'h0;
      dmem_din       = 32'h0;
      dmem_mem_read  = 1'b0;
      dmem_mem_write = 1'b0;
      if (!reset) begin
         unique case (state_q)
            IDLE: begin
               if (cause != 2'b00) begin
                  access_fault = 1'b1;
                  fault_cause  = cause;
               end else if (req_mem_read) begin
                  dmem_mem_read = 1'b1;
                  dmem_addr     = word_addr;
                  load_data     = ext_data;
               end else if (req_mem_write &&
                            req_funct3 == F_W) begin
                  dmem_mem_write = 1'b1;
                  dmem_addr      = word_addr;
                  dmem_din       = req_wdata;
               end else if (req_mem_write) begin
                  dmem_mem_read = 1'b1;
                  dmem_addr     = word_addr;
                  stall         = 1'b1;
                  addr_d        = word_addr;
                  merged_d      = merged_word;
                  state_d       = RMW_WR;
               end
            end
            RMW_WR: begin
               dmem_mem_write = 1'b1;
               dmem_addr      = addr_q;
               dmem_din       = merged_q;
               rmw_done       = 1'b1;
               state_d        = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= 32'h0;
         merged_q <= 32'h0;
         rmw_q    <= 32'h0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         merged_q <= merged_d;
         if (rmw_done) rmw_q <= rmw_q + 32'd1;
      end
   end

   assign rmw_count = reset ? 32'h0 : rmw_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: random + directed scoreboard bench with a
// word-level reference model of memory and the store counter.
module tb_dmem_access_unit;

   localparam int DEPTH = 16384;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_mem_read = 1'b0;
   logic        req_mem_write = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic [31:0] load_data;
   logic        stall;
   logic        access_fault;
   logic [1:0]  fault_cause;
   logic [31:0] rmw_count;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_din;
   logic        dmem_mem_read;
   logic        dmem_mem_write;
   logic [31:0] dmem_dout;

   always #5 clk = ~clk;

   dmem_access_unit #(.MEM_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_mem_read  (req_mem_read),
      .req_mem_write (req_mem_write),
      .req_funct3    (req_funct3),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .load_data     (load_data),
      .stall         (stall),
      .access_fault  (access_fault),
      .fault_cause   (fault_cause),
      .rmw_count     (rmw_count),
      .dmem_addr     (dmem_addr),
      .dmem_din      (dmem_din),
      .dmem_mem_read (dmem_mem_read),
      .dmem_mem_write(dmem_mem_write),
      .dmem_dout     (dmem_dout)
   );

   logic [31:0] mem [0:DEPTH-1];

   always @(posedge clk) begin
      if (dmem_mem_write === 1'b1 &&
          dmem_addr[31:2] < 30'(DEPTH))
         mem[dmem_addr[15:2]] <= dmem_din;
   end

   assign dmem_dout = (dmem_addr[31:2] < 30'(DEPTH))
                      ? mem[dmem_addr[15:2]] : 32'h0;

   typedef struct {
      string       name;
      logic [31:0] ld;
      logic        st;
      logic        rd;
      logic        wr;
      logic        af;
      logic [1:0]  fc;
      logic [31:0] cnt;
      logic [31:0] din;
      logic [31:0] adr;
      bit          cd;
      bit          ca;
   } exp_t;

   exp_t        q[$];
   logic [31:0] ref_mem [0:DEPTH-1];
   logic [31:0] m_cnt = 32'h0;
   bit          drv_done = 1'b0;
   int          total = 0;
   int          bad = 0;

   function automatic exp_t base(input string nm);
      exp_t e;
      e.name = nm;
      e.ld = 32'h0; e.st = 1'b0; e.rd = 1'b0; e.wr = 1'b0;
      e.af = 1'b0;  e.fc = 2'b00; e.cnt = m_cnt;
      e.din = 32'h0; e.adr = 32'h0; e.cd = 1'b0; e.ca = 1'b0;
      return e;
   endfunction

   function automatic logic [1:0] m_cause(
      input logic r, input logic w,
      input logic [2:0] f, input logic [31:0] a);
      if ((r && w) || f == 3 || f == 6 || f == 7 ||
          (w && (f == 4 || f == 5)))
         return 2'b11;
      if ((f == 2 && a % 4 != 0) ||
          ((f == 1 || f == 5) && a % 2 != 0))
         return 2'b01;
      if (a / 4 >= DEPTH) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [31:0] m_load(
      input logic [2:0] f, input logic [31:0] a);
      logic [31:0] wd, v;
      wd = ref_mem[int'(a >> 2)];
      v  = wd >> (8 * (a % 4));
      case (f)
         3'd0: begin
            v = v & 32'hFF;
            if (v >= 128) v = v + 32'hFFFF_FF00;
         end
         3'd4: v = v & 32'hFF;
         3'd1: begin
            v = v & 32'hFFFF;
            if (v >= 32768) v = v + 32'hFFFF_0000;
         end
         3'd5: v = v & 32'hFFFF;
         default: v = wd;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] m_merge(
      input logic [2:0] f, input logic [31:0] a,
      input logic [31:0] d, input logic [31:0] old);
      logic [31:0] mask;
      int sh;
      sh   = 8 * int'(a % 4);
      mask = (f == 3'd0) ? 32'hFF : 32'hFFFF;
      return (old & ~(mask << sh)) | ((d & mask) << sh);
   endfunction

   task automatic do_reset(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         reset = 1'b1;
         req_mem_read = 1'b0; req_mem_write = 1'b0;
         m_cnt = 32'h0;
         e = base("reset");
         e.cd = 1'b1; e.ca = 1'b1;
         q.push_back(e);
      end
   endtask

   task automatic drive(input string nm, input logic r,
                        input logic w, input logic [2:0] f,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input bit abort = 1'b0);
      exp_t e;
      logic [1:0] c;
      logic [31:0] mrg;
      int idx;
      @(posedge clk); #1;
      reset = 1'b0;
      req_mem_read = r; req_mem_write = w;
      req_funct3 = f; req_addr = a; req_wdata = d;
      e = base(nm);
      c = (r || w) ? m_cause(r, w, f, a) : 2'b00;
      idx = int'(a >> 2);
      if (!r && !w) begin
         q.push_back(e);
      end else if (c != 2'b00) begin
         e.af = 1'b1; e.fc = c;
         q.push_back(e);
      end else if (r) begin
         e.rd = 1'b1; e.ca = 1'b1;
         e.adr = a & 32'hFFFF_FFFC;
         e.ld = m_load(f, a);
         q.push_back(e);
      end else if (f == 3'd2) begin
         e.wr = 1'b1; e.ca = 1'b1; e.cd = 1'b1;
         e.adr = a; e.din = d;
         q.push_back(e);
         ref_mem[idx] = d;
      end else begin
         e.rd = 1'b1; e.st = 1'b1; e.ca = 1'b1;
         e.adr = a & 32'hFFFF_FFFC;
         q.push_back(e);
         mrg = m_merge(f, a, d, ref_mem[idx]);
         @(posedge clk); #1;
         if (abort) begin
            reset = 1'b1;
            m_cnt = 32'h0;
            e = base({nm, "_abort"});
            e.cd = 1'b1; e.ca = 1'b1;
            q.push_back(e);
         end else begin
            e = base({nm, "_wr"});
            e.wr = 1'b1; e.ca = 1'b1; e.cd = 1'b1;
            e.adr = a & 32'hFFFF_FFFC; e.din = mrg;
            q.push_back(e);
            ref_mem[idx] = mrg;
            m_cnt = m_cnt + 32'd1;
         end
      end
   endtask

   initial begin
      logic r, w;
      logic [2:0] f;
      logic [31:0] a;
      int k;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
      do_reset(2);
      for (int i = 0; i < 64; i++)
         drive("clr", 0, 1, 3'd2, 32'(i * 4), 32'h0);

      drive("sw0", 0, 1, 3'd2, 32'h0, 32'h80FF7F01);
      drive("sw10", 0, 1, 3'd2, 32'h10, 32'h11223344);
      drive("lb3", 1, 0, 3'd0, 32'h3, 32'h0);
      drive("lbu3", 1, 0, 3'd4, 32'h3, 32'h0);
      drive("lh2", 1, 0, 3'd1, 32'h2, 32'h0);
      drive("lhu0", 1, 0, 3'd5, 32'h0, 32'h0);
      drive("lw0", 1, 0, 3'd2, 32'h0, 32'h0);
      drive("sb11", 0, 1, 3'd0, 32'h11, 32'hAB);
      drive("lw10", 1, 0, 3'd2, 32'h10, 32'h0);
      drive("sh22", 0, 1, 3'd1, 32'h22, 32'hBEEF);
      drive("sw20", 0, 1, 3'd2, 32'h20, 32'h12345678);
      drive("lw20", 1, 0, 3'd2, 32'h20, 32'h0);
      drive("f_lw6", 1, 0, 3'd2, 32'h6, 32'h0);
      drive("f_lh5", 1, 0, 3'd1, 32'h5, 32'h0);
      drive("f_oor", 1, 0, 3'd2, 32'h10000, 32'h0);
      drive("f_011", 1, 0, 3'd3, 32'h0, 32'h0);
      drive("f_both", 1, 1, 3'd2, 32'h0, 32'h0);
      drive("f_sbu", 0, 1, 3'd4, 32'h3, 32'h0);
      drive("idle", 0, 0, 3'd0, 32'h0, 32'h0);
      drive("sb_rst", 0, 1, 3'd0, 32'h4, 32'h55, 1'b1);
      drive("lw4", 1, 0, 3'd2, 32'h4, 32'h0);
      drive("idle", 0, 0, 3'd0, 32'h0, 32'h0);

      @(negedge clk); #1;
      dut.rmw_q = 32'hFFFF_FFFF;
      m_cnt = 32'hFFFF_FFFF;
      drive("sb_wrap", 0, 1, 3'd0, 32'h9, 32'h5A);
      drive("idle", 0, 0, 3'd0, 32'h0, 32'h0);

      for (int i = 0; i < 400; i++) begin
         k = $urandom_range(0, 15);
         r = (k < 7) || (k == 14);
         w = (k >= 7 && k < 14) || (k == 14);
         if ($urandom_range(0, 4) != 0) begin
            case ($urandom_range(0, 4))
               0: f = 3'd0;
               1: f = 3'd1;
               2: f = 3'd2;
               3: f = 3'd4;
               default: f = 3'd5;
            endcase
         end else begin
            f = 3'($urandom_range(0, 7));
         end
         a = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 15) == 0)
            a = a | (32'h0001_0000 << $urandom_range(0, 15));
         drive("rnd", r, w, f, a, $urandom);
      end
      drive("idle", 0, 0, 3'd0, 32'h0, 32'h0);
      drv_done = 1'b1;
   end

   initial begin
      exp_t e;
      bit ok;
      int cyc;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            ok = (load_data === e.ld) && (stall === e.st) &&
                 (dmem_mem_read === e.rd) &&
                 (dmem_mem_write === e.wr) &&
                 (access_fault === e.af) &&
                 (fault_cause === e.fc) &&
                 (rmw_count === e.cnt) &&
                 (!e.ca || dmem_addr === e.adr) &&
                 (!e.cd || dmem_din === e.din);
            if (!ok) begin
               bad++;
               $display(
                 "FAIL %s: got ld=%h st=%b rd=%b wr=%b af=%b fc=%b adr=%h din=%h cnt=%h; want ld=%h st=%b rd=%b wr=%b af=%b fc=%b adr=%h din=%h cnt=%h",
                 e.name, load_data, stall, dmem_mem_read,
                 dmem_mem_write, access_fault, fault_cause,
                 dmem_addr, dmem_din, rmw_count,
                 e.ld, e.st, e.rd, e.wr, e.af, e.fc,
                 e.adr, e.din, e.cnt);
            end
         end
         if (drv_done && q.size() == 0) begin
            for (int i = 0; i < 64; i++) begin
               total++;
               if (mem[i] !== ref_mem[i]) begin
                  bad++;
                  $display("FAIL mem[%0d]: got %h want %h",
                           i, mem[i], ref_mem[i]);
               end
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end
         if (cyc > 20000) begin
            bad++;
            $display("FAIL timeout: got %0d cycles want <= 20000",
                     cyc);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end
      end
   end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- MEM-stage load/store unit between the EX/MEM pipeline register and the word-addressed DataMemory.
- Converts RV32I sub-word accesses into word accesses:
  - lb/lh/lbu/lhu: byte/halfword extraction, then sign or zero extension.
  - sb/sh: two-cycle read-modify-write (RMW), because DataMemory writes whole words only.
- Detects misaligned, out-of-range and illegal accesses.
- Drives a stall to the hazard unit while an RMW is in flight.

Parameters:
- MEM_DEPTH, 16384: number of 32-bit words in DataMemory; word index >= MEM_DEPTH is out of range.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- req_mem_read  input  1  load request from EX/MEM
- req_mem_write  input  1  store request from EX/MEM
- req_funct3  input  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  input  32  byte address
- req_wdata  input  32  store data (rs2); low bits used for sb/sh
- load_data  output  32  extended load result
- stall  output  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle
- access_fault  output  1  request rejected, no memory access
- fault_cause  output  2  00 none, 01 misaligned, 10 out of range, 11 illegal op
- rmw_count  output  32  completed sub-word stores
- dmem_addr  output  32  byte address to DataMemory (bits [1:0] forced 0)
- dmem_din  output  32  word to write
- dmem_mem_read  output  1  read enable
- dmem_mem_write  output  1  write enable
- dmem_dout  input  32  asynchronous read data from DataMemory

Behaviour:
- Clocking: clk is the only clock; reset is synchronous, active-high, sampled on posedge clk.
- Reset values:
  - state=IDLE; latched address and merged word = 0; rmw_count = 0.
  - All outputs 0 while reset is high; no dmem write is issued in a reset cycle.
- FSM states:
  - IDLE -> RMW_WR: valid sb/sh in IDLE.
  - RMW_WR -> IDLE: always, after one cycle.
  - RMW_WR -> IDLE on reset: RMW aborted, no write.
- Fault checks (IDLE only, combinational). Priority: illegal(11) > misaligned(01) > out of range(10).
  - Illegal: req_mem_read and req_mem_write both high; or funct3 in {011,110,111} with either enable; or store with funct3 100/101.
  - Misaligned: w with addr[1:0]!=0; h/hu with addr[0]!=0.
  - Out of range: (addr>>2) >= MEM_DEPTH.
  - On any fault: access_fault=1; dmem_mem_read=0; dmem_mem_write=0; load_data=0; no stall.
- Loads (IDLE): single cycle, zero latency.
  - dmem_mem_read=1 and dmem_addr={addr[31:2],2'b00}.
  - Byte select = addr[1:0]; halfword select = addr[1].
  - lb/lh sign-extend, lbu/lhu zero-extend, lw passes dmem_dout through.
  - stall=0. load_data=0 whenever no valid load is in progress.
- sw (IDLE): dmem_mem_write=1, dmem_din=req_wdata, write occurs at the same posedge; stall=0.
- sb/sh, cycle 1 (IDLE):
  - dmem_mem_read=1; merged word = dmem_dout with the target byte/half lane replaced by req_wdata[7:0] / [15:0].
  - Merged word and word address are registered.
  - stall=1; next state RMW_WR.
- sb/sh, cycle 2 (RMW_WR):
  - dmem_mem_write=1, dmem_din/dmem_addr from registers, dmem_mem_read=0, stall=0.
  - rmw_count increments (wraps at 2^32-1 -> 0).
  - Request inputs are ignored; the pipeline holds the same request, which is not reissued.
- No request (both enables 0): all dmem controls 0, no fault.
- Reset mid-RMW: no write to memory and rmw_count is not incremented.

Test Plan:
- Load extension: mem word 0x0 = 0x80FF7F01.
  - lb addr 0x3 -> 0xFFFFFF80
  - lbu addr 0x3 -> 0x00000080
  - lh addr 0x2 -> 0xFFFF80FF
  - lhu addr 0x0 -> 0x00007F01
  - lw addr 0x0 -> 0x80FF7F01
  - stall=0 throughout.
- sb RMW: word 0x10 = 0x11223344; sb addr 0x11, wdata 0xAB.
  - Cycle 1: stall=1, dmem_mem_read=1.
  - Cycle 2: dmem_mem_write=1, dmem_din=0x1122AB44.
  - rmw_count 0->1; a following lw 0x10 returns 0x1122AB44.
- sh then sw back-to-back:
  - sh addr 0x22 wdata 0xBEEF onto 0x00000000 -> word 0xBEEF0000, two cycles.
  - Next sw addr 0x20 wdata 0x12345678 writes in one cycle, no stall.
- Faults, each with access_fault=1, no dmem enables, no state change:
  - lw addr 0x6 -> cause 01.
  - lh addr 0x5 -> cause 01.
  - lw addr 0x10000 (word 16384) -> cause 10.
  - funct3 011 load -> cause 11.
  - Both enables high -> cause 11.
  - sb to addr 0x3 with funct3 100 -> cause 11.
- Reset during RMW_WR: sb issued, reset asserted in cycle 2.
  - dmem_mem_write=0, rmw_count stays 0, state IDLE, memory word unchanged.
- Counter wrap: force rmw_count to 0xFFFFFFFF via 2^32-1 sb (or bench preload hook) -> next sb completion gives 0x00000000.
